sequential_shift_add_multiplier: RTL and testbench
==================================================

// Module: sequential_shift_add_multiplier
// PURPOSE
//  Multi-cycle shift-and-add multiplier producing a 2*width-bit product of two width-bit operands.
//  Supports unsigned and two's-complement signed operands via magnitude/sign-fix.
//  Companion to the non-restoring divider in the ALU library.
//  Shares its start/busy/done handshake so both can sit behind one ALU sequencer.
// PARAMETERS
//  width    8  operand width in bits; product is 2*width bits
//  N_width  4  iteration counter width; must satisfy 2**N_width > width
// PORTS
//  clk           input   1          rising-edge clock
//  rst           input   1          asynchronous, active-high reset
//  start         input   1          request; sampled only in IDLE
//  signed_op     input   1          1 = two's-complement operands, 0 = unsigned; sampled with start
//  multiplicand  input   width      operand A; sampled with start
//  multiplier    input   width      operand B; sampled with start
//  product       output  2*width    result; registered, holds until next accepted start completes
//  busy          output  1          high while an operation is in progress
//  done          output  1          one-cycle pulse when product is updated
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE; product=0, busy=0, done=0.
//  Reset also clears all internal registers (acc, mplier_reg, mcand_reg, neg_flag, N).
//  rst asserted mid-operation aborts immediately; product returns to 0 and no done pulse is issued.
//  States: IDLE, CALC, FIX.
//  IDLE: done=0 except in the first IDLE cycle after FIX. On edge with start=1:
//   - mcand_reg <= |multiplicand|, mplier_reg <= |multiplier| when signed_op, else raw operands.
//   - Magnitude is (~x+1) when x[width-1]=1. -2**(width-1) maps to 2**(width-1), which fits unsigned width.
//   - neg_flag <= signed_op & (multiplicand[width-1] ^ multiplier[width-1]).
//   - acc (width+1 bits) <= 0, N <= width, busy <= 1, state <= CALC.
//  CALC, one iteration per clock:
//   - sum = acc + (mplier_reg[0] ? {1'b0,mcand_reg} : 0), width+1 bits, no overflow loss.
//   - {acc, mplier_reg} <= {sum, mplier_reg} >> 1.
//   - N <= N-1.
//   - When N==1 at the edge, state <= FIX.
//   - Exactly width CALC cycles, with no early exit on zero operands, so latency is fixed.
//  FIX: mag = {acc[width-1:0], mplier_reg} (2*width bits).
//   - On the edge: product <= neg_flag ? (~mag+1) : mag; done <= 1; busy <= 0; state <= IDLE.
//  Latency: start accepted at edge k; product valid and done=1 after edge k+width+1.
//   - busy is high from edge k through edge k+width+1 (exclusive).
//  Handshake rules:
//   - start while busy=1 is ignored; operands are not re-sampled.
//   - start in the done cycle (state IDLE) is accepted. The old product holds until the new FIX edge.
//   - Operand inputs may change freely after the accepting edge.
//  Sign-fix result for a zero magnitude is 0 regardless of neg_flag.
//  Signed product of two -2**(width-1) operands = 2**(2*width-2), which is representable.
//  No error/overflow output: every width x width product fits in 2*width bits.
// TESTING (width=8)
//  1. Unsigned 0xFF*0xFF -> product=0xFE01; done pulses 9 cycles after start edge; busy high 9 cycles.
//  2. Signed 0x80*0x80 (-128*-128) -> 0x4000; signed 0xFD*0x05 (-3*5) -> 0xFFF1 (-15).
//  3. Same bits, mode differs: unsigned 0x80*0x02 -> 0x0100; signed -> 0xFF00. Signed 0x00*0x9C -> 0x0000, same latency.
//  4. start re-pulsed with new operands mid-CALC -> ignored; first result unchanged, exactly one done pulse.
//  5. start held high in the done cycle with 7*6 -> second done 9 cycles later, product=0x002A; first product held until then.
//  6. rst asserted mid-operation, asynchronously and between edges -> product=0, busy=0, done=0 at once; next start behaves normally.

Source files
------------

// File: rtl/sequential_shift_add_multiplier.sv
// ---------------------------------------------------------------------------------------------
// sequential_shift_add_multiplier
//   Multi-cycle shift-and-add multiplier. It produces a 2*width-bit product from two width-bit
//   operands. Signed operands are handled by multiplying their magnitudes and then negating the
//   result when the operand signs differ. Latency is fixed: the product is valid, and done
//   pulses, width+1 clock edges after the edge that accepts start.
//
// Parameters
//   width        operand width; the product is 2*width bits
//   N_width      iteration counter width; 2**N_width must be greater than width
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request; sampled only in IDLE
//   signed_op    1 = two's-complement operands, 0 = unsigned; sampled with start
//   multiplicand operand A; sampled with start
//   multiplier   operand B; sampled with start
//   product      registered result; holds until the next accepted operation completes
//   busy         high while an operation is in progress
//   done         one-cycle pulse when product is updated
// ---------------------------------------------------------------------------------------------
module sequential_shift_add_multiplier #(
    parameter int width   = 8,
    parameter int N_width = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [width-1:0]     multiplicand,
    input  logic [width-1:0]     multiplier,
    output logic [2*width-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_t;

    state_t               r_state, w_state_nxt;
    logic [width:0]       r_acc, w_acc_nxt;
    logic [width-1:0]     r_mplier, w_mplier_nxt;
    logic [width-1:0]     r_mcand, w_mcand_nxt;
    logic                 r_neg, w_neg_nxt;
    logic [N_width-1:0]   r_cnt, w_cnt_nxt;
    logic [2*width-1:0]   r_product, w_product_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;

    logic [width-1:0]     w_a_mag, w_b_mag;
    logic [width:0]       w_sum;
    logic [2*width-1:0]   w_mag, w_fixed;

    // -2**(width-1) negates to itself, which read as unsigned is the correct magnitude.
    assign w_a_mag = (signed_op && multiplicand[width-1]) ? (~multiplicand + width'(1))
                                                          : multiplicand;
    assign w_b_mag = (signed_op && multiplier[width-1]) ? (~multiplier + width'(1))
                                                        : multiplier;

    // acc is always below 2**width after a shift, so width+1 bits hold the sum without loss.
    assign w_sum   = r_acc + (r_mplier[0] ? {1'b0, r_mcand} : '0);
    assign w_mag   = {r_acc[width-1:0], r_mplier};
    // Negating a zero magnitude gives zero, so no special case is needed.
    assign w_fixed = r_neg ? (~w_mag + (2*width)'(1)) : w_mag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_mcand   <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_mplier  <= w_mplier_nxt;
            r_mcand   <= w_mcand_nxt;
            r_neg     <= w_neg_nxt;
            r_cnt     <= w_cnt_nxt;
            r_product <= w_product_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_mplier_nxt  = r_mplier;
        w_mcand_nxt   = r_mcand;
        w_neg_nxt     = r_neg;
        w_cnt_nxt     = r_cnt;
        w_product_nxt = r_product;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_mcand_nxt  = w_a_mag;
                    w_mplier_nxt = w_b_mag;
                    w_neg_nxt    = signed_op & (multiplicand[width-1] ^ multiplier[width-1]);
                    w_acc_nxt    = '0;
                    w_cnt_nxt    = N_width'(width);
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = StCalc;
                end
            end
            StCalc: begin
                // {acc, mplier} <= {sum, mplier} >> 1
                w_acc_nxt    = {1'b0, w_sum[width:1]};
                w_mplier_nxt = {w_sum[0], r_mplier[width-1:1]};
                w_cnt_nxt    = r_cnt - N_width'(1);
                if (r_cnt == N_width'(1)) begin
                    w_state_nxt = StFix;
                end
            end
            StFix: begin
                w_product_nxt = w_fixed;
                w_done_nxt    = 1'b1;
                w_busy_nxt    = 1'b0;
                w_state_nxt   = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_sequential_shift_add_multiplier.sv
// ---------------------------------------------------------------------------------------------
// tb_sequential_shift_add_multiplier
//   Scoreboard bench for the shift-and-add multiplier (width = 8). The driver pushes the
//   accepting cycle and the expected product for every start it issues. A monitor samples on
//   the falling edge and checks done, busy and product against those entries and against the
//   last completed product.
// ---------------------------------------------------------------------------------------------
module tb_sequential_shift_add_multiplier;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          signed_op = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic [2*W-1:0] product;
    logic          busy;
    logic          done;

    sequential_shift_add_multiplier #(
        .width   (W),
        .N_width (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_op    (signed_op),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int             cyc;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t           q[$];
    logic [2*W-1:0] last_prod = '0;
    int             cyc = 0;
    int             n_total = 0;
    int             n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer multiplication, truncated to the product width.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        int pa, pb, p;
        if (s) begin
            pa = int'($signed(a));
            pb = int'($signed(b));
        end else begin
            pa = int'(a);
            pb = int'(b);
        end
        p = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Call just after a falling edge; returns after the next falling edge (accepting edge seen).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] exp);
        exp_t e;
        multiplicand = a;
        multiplier   = b;
        signed_op    = s;
        start        = 1'b1;
        e.cyc  = cyc + 1;
        e.prod = exp;
        q.push_back(e);
        @(negedge clk);
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        signed_op    = 1'($urandom);
    endtask

    // Monitor: busy covers edges k..k+W, done and the new product appear after edge k+W+1.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_done, exp_busy;
            exp_done = 1'b0;
            exp_busy = 1'b0;
            if (q.size() > 0) begin
                exp_busy = (cyc >= q[0].cyc) && (cyc <= q[0].cyc + W);
                exp_done = (cyc == q[0].cyc + W + 1);
                if (exp_done) begin
                    last_prod = q[0].prod;
                    void'(q.pop_front());
                end
            end
            check("done", 32'(done), 32'(exp_done));
            check("busy", 32'(busy), 32'(exp_busy));
            check("product", 32'(product), 32'(last_prod));
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_product", 32'(product), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases: each returns to the done cycle before the next start.
        issue(8'hFF, 8'hFF, 1'b0, 16'hFE01); repeat (W + 1) @(negedge clk);
        issue(8'h80, 8'h80, 1'b1, 16'h4000); repeat (W + 1) @(negedge clk);
        issue(8'hFD, 8'h05, 1'b1, 16'hFFF1); repeat (W + 1) @(negedge clk);
        issue(8'h80, 8'h02, 1'b0, 16'h0100); repeat (W + 1) @(negedge clk);
        issue(8'h80, 8'h02, 1'b1, 16'hFF00); repeat (W + 1) @(negedge clk);
        issue(8'h00, 8'h9C, 1'b1, 16'h0000); repeat (W + 1) @(negedge clk);
        // Start in the done cycle is accepted; earlier product must hold until the new FIX.
        issue(8'd7, 8'd6, 1'b0, 16'h002A); repeat (W + 1) @(negedge clk);
        @(negedge clk);

        // Start pulsed mid-calculation must be ignored.
        issue(8'h12, 8'h34, 1'b0, 16'h03A8);
        repeat (3) @(negedge clk);
        multiplicand = 8'hAA; multiplier = 8'h55; signed_op = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) @(negedge clk);

        // Asynchronous reset between edges while busy.
        issue(8'h33, 8'h44, 1'b0, 16'h0D8C);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_product", 32'(product), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        q.delete();
        last_prod = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(8'hFB, 8'hFB, 1'b1, 16'h0019); repeat (W + 1) @(negedge clk);

        // Random operations, sometimes back to back in the done cycle.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            if (i % 10 == 0) a = 8'h80;
            if (i % 10 == 1) b = 8'h00;
            issue(a, b, s, ref_mul(a, b, s));
            repeat (W + 1) @(negedge clk);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (W + 4) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
